// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the 32x32 register file: a small FIFO that drains into a registered write port.
// Build option: define REGWB_BYPASS_EN to forward pending write data instead of flagging hazards.
module regfile_wb_ctrl #(
    parameter int DEPTH   = 4,
    parameter int PTR_W   = 2,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [4:0]       wb_addr,
    input  logic [31:0]      wb_data,
    input  logic             rf_hold,
    output logic             we,
    output logic [4:0]       waddr,
    output logic [31:0]      wdata,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic             hazard1,
    output logic             hazard2,
    output logic             fwd_valid1,
    output logic [31:0]      fwd_data1,
    output logic             fwd_valid2,
    output logic [31:0]      fwd_data2,
    output logic [PTR_W:0]   pending
);

    logic [4:0]     addr_q [DEPTH];
    logic [4:0]     addr_d [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    data_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    logic           we_q, we_d;
    logic [4:0]     waddr_q, waddr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           push, store, pop;
    logic           match1, match2;
    logic [31:0]    fdata1, fdata2;

    // Ready depends only on current occupancy, so a full FIFO never passes through.
    assign wb_ready = ~rst & (count_q != (PTR_W+1)'(DEPTH));
    assign push     = wb_valid & wb_ready;
    assign store    = push & ~(DROP_R0 && (wb_addr == 5'd0));
    assign pop      = (count_q != '0) & ~rf_hold;

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{PTR_W{1'b0}}, store} - {{PTR_W{1'b0}}, pop};
        we_d     = pop;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        if (store) begin
            addr_d[wr_ptr_q] = wb_addr;
            data_d[wr_ptr_q] = wb_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            waddr_d  = addr_q[rd_ptr_q];
            wdata_d  = data_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    // Scan oldest to newest after the output register so the youngest match wins.
    always_comb begin
        match1 = we_q && (waddr_q == raddr1);
        match2 = we_q && (waddr_q == raddr2);
        fdata1 = '0;
        fdata2 = '0;
`ifdef REGWB_BYPASS_EN
        if (match1) fdata1 = wdata_q;
        if (match2) fdata2 = wdata_q;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count_q) begin
                if (addr_q[rd_ptr_q + PTR_W'(i)] == raddr1) begin
                    match1 = 1'b1;
`ifdef REGWB_BYPASS_EN
                    fdata1 = data_q[rd_ptr_q + PTR_W'(i)];
`endif
                end
                if (addr_q[rd_ptr_q + PTR_W'(i)] == raddr2) begin
                    match2 = 1'b1;
`ifdef REGWB_BYPASS_EN
                    fdata2 = data_q[rd_ptr_q + PTR_W'(i)];
`endif
                end
            end
        end
        if (rst || raddr1 == 5'd0) match1 = 1'b0;
        if (rst || raddr2 == 5'd0) match2 = 1'b0;
    end

`ifdef REGWB_BYPASS_EN
    assign hazard1    = 1'b0;
    assign hazard2    = 1'b0;
    assign fwd_valid1 = match1;
    assign fwd_valid2 = match2;
    assign fwd_data1  = match1 ? fdata1 : 32'd0;
    assign fwd_data2  = match2 ? fdata2 : 32'd0;
`else
    assign hazard1    = match1;
    assign hazard2    = match2;
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = fdata1;
    assign fwd_data2  = fdata2;
`endif

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign pending = rst ? '0 : count_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized bench for regfile_wb_ctrl against a queue-based model of the writeback path.
// Honours REGWB_BYPASS_EN the same way the design does.
module tb_regfile_wb_ctrl;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst, wb_valid, wb_ready, rf_hold, we;
    logic [4:0]  wb_addr, waddr, raddr1, raddr2;
    logic [31:0] wb_data, wdata, fwd_data1, fwd_data2;
    logic        hazard1, hazard2, fwd_valid1, fwd_valid2;
    logic [PTR_W:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    wb_t         q[$];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    regfile_wb_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DROP_R0(1'b1)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .rf_hold(rf_hold),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
        .fwd_valid1(fwd_valid1), .fwd_data1(fwd_data1),
        .fwd_valid2(fwd_valid2), .fwd_data2(fwd_data2), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Newest pending write to a register, looking at the queue first and then the output register.
    function automatic void lookup(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (ra == 5'd0 || rst) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].addr == ra) begin
                hit = 1'b1;
                d   = q[i].data;
                return;
            end
        end
        if (m_we && m_waddr == ra) begin
            hit = 1'b1;
            d   = m_wdata;
        end
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic hold, input logic [4:0] r1, input logic [4:0] r2);
        logic h1, h2, rdy;
        logic [31:0] d1, d2;
        @(negedge clk);
        rst = r; wb_valid = v; wb_addr = a; wb_data = d; rf_hold = hold;
        raddr1 = r1; raddr2 = r2;
        #1;
        rdy = !r && (q.size() != DEPTH);
        lookup(r1, h1, d1);
        lookup(r2, h2, d2);
        check("wb_ready", {31'd0, wb_ready}, {31'd0, rdy});
        check("pending", {29'd0, pending}, r ? 32'd0 : 32'(q.size()));
        check("we", {31'd0, we}, {31'd0, m_we});
        check("waddr", {27'd0, waddr}, {27'd0, m_waddr});
        check("wdata", wdata, m_wdata);
`ifdef REGWB_BYPASS_EN
        check("hazard1", {31'd0, hazard1}, 32'd0);
        check("hazard2", {31'd0, hazard2}, 32'd0);
        check("fwd_valid1", {31'd0, fwd_valid1}, {31'd0, h1});
        check("fwd_valid2", {31'd0, fwd_valid2}, {31'd0, h2});
        check("fwd_data1", fwd_data1, d1);
        check("fwd_data2", fwd_data2, d2);
`else
        check("hazard1", {31'd0, hazard1}, {31'd0, h1});
        check("hazard2", {31'd0, hazard2}, {31'd0, h2});
        check("fwd_valid1", {31'd0, fwd_valid1}, 32'd0);
        check("fwd_valid2", {31'd0, fwd_valid2}, 32'd0);
        check("fwd_data1", fwd_data1, 32'd0);
        check("fwd_data2", fwd_data2, 32'd0);
`endif
        @(posedge clk);
        if (r) begin
            q.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            if (q.size() != 0 && !hold) begin
                m_we = 1'b1; m_waddr = q[0].addr; m_wdata = q[0].data;
                void'(q.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (v && rdy && a != 5'd0) q.push_back('{addr: a, data: d});
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; rf_hold = 1'b0;
        raddr1 = '0; raddr2 = '0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        repeat (2) @(posedge clk);
        cycle(1, 0, 0, 0, 0, 3, 9);
        // single write of all-ones to r3
        cycle(0, 1, 3, 32'hFFFF_FFFF, 0, 3, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 3, 0);
        // fill under hold, refuse a fifth, then drain while the fifth is held valid
        cycle(0, 1, 6, 1, 1, 6, 12);
        cycle(0, 1, 9, 2, 1, 6, 12);
        cycle(0, 1, 12, 3, 1, 6, 12);
        cycle(0, 1, 6, 4, 1, 6, 12);
        cycle(0, 1, 20, 5, 1, 6, 20);
        cycle(0, 1, 20, 5, 0, 6, 20);
        cycle(0, 1, 20, 5, 0, 6, 20);
        repeat (6) cycle(0, 0, 0, 0, 0, 6, 20);
        // r0 writes are swallowed
        cycle(0, 1, 0, 32'h1234, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);
        // two writes to the same register
        cycle(0, 1, 9, 32'hAA, 1, 0, 9);
        cycle(0, 1, 9, 32'hBB, 1, 0, 9);
        repeat (5) cycle(0, 0, 0, 0, 0, 0, 9);
        // reset arriving mid-drain
        cycle(0, 1, 1, 11, 1, 1, 2);
        cycle(0, 1, 2, 22, 1, 1, 2);
        cycle(0, 1, 3, 33, 0, 1, 2);
        cycle(0, 1, 4, 44, 0, 1, 2);
        cycle(1, 0, 0, 0, 0, 1, 2);
        repeat (3) cycle(0, 0, 0, 0, 0, 1, 2);
        for (int n = 0; n < 800; n++) begin
            cycle(($urandom_range(59) == 0), ($urandom_range(3) != 0),
                  5'($urandom_range(7)), $urandom, ($urandom_range(3) == 0),
                  5'($urandom_range(7)), 5'($urandom_range(7)));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
